// File: rtl/lc3b_mem_ctrl.sv
// LC-3b memory controller: serves 16-bit held CPU requests from an 8-bit synchronous SRAM
// as low/high byte accesses, each stretched by WAIT_STATES cycles, answered by a one-cycle mem_resp.
module lc3b_mem_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] mem_address,
    input  logic [15:0] mem_wdata,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [1:0]  mem_byte_enable,
    output logic [15:0] mem_rdata,
    output logic        mem_resp,
    output logic [15:0] sram_addr,
    output logic [7:0]  sram_wdata,
    input  logic [7:0]  sram_rdata,
    output logic        sram_ce,
    output logic        sram_we
);

    typedef enum logic [2:0] {
        IDLE,
        LO_ACC,
        HI_ACC,
        RESP,
        RELEASE
    } state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_STATES - 1);

    state_t      state, state_next;
    logic [3:0]  wait_cnt;
    logic [14:0] addr_q;
    logic [15:0] wdata_q;
    logic [15:0] rdata_q;
    logic [1:0]  be_q;
    logic        op_rd_q;
    logic        req;
    logic        wait_done;

    // Word alignment discards the CPU's byte-select bit.
    logic unused_addr_bit;
    assign unused_addr_bit = mem_address[0];

    assign req       = mem_read | mem_write;
    assign wait_done = (wait_cnt == WAIT_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 15'd0;
            wdata_q  <= 16'd0;
            rdata_q  <= 16'd0;
            be_q     <= 2'b00;
            op_rd_q  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    wait_cnt <= 4'd0;
                    if (req) begin
                        addr_q  <= mem_address[15:1];
                        wdata_q <= mem_wdata;
                        be_q    <= mem_byte_enable;
                        op_rd_q <= mem_read;
                    end
                end
                LO_ACC, HI_ACC: begin
                    if (wait_done) begin
                        wait_cnt <= 4'd0;
                        if (op_rd_q) begin
                            if (state == LO_ACC) rdata_q[7:0]  <= sram_rdata;
                            else                 rdata_q[15:8] <= sram_rdata;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                default: wait_cnt <= 4'd0;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (mem_read || mem_byte_enable[0]) state_next = LO_ACC;
                    else if (mem_byte_enable[1])        state_next = HI_ACC;
                    else                                state_next = RESP;
                end
            end
            LO_ACC: begin
                if (wait_done) state_next = (op_rd_q || be_q[1]) ? HI_ACC : RESP;
            end
            HI_ACC: begin
                if (wait_done) state_next = RESP;
            end
            RESP:    state_next = RELEASE;
            RELEASE: begin
                // A request still held from the finished transaction must not restart it.
                if (!req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sram_ce    = 1'b0;
        sram_we    = 1'b0;
        sram_addr  = 16'h0000;
        sram_wdata = 8'h00;
        if (state == LO_ACC || state == HI_ACC) begin
            sram_ce   = 1'b1;
            sram_we   = ~op_rd_q;
            sram_addr = {addr_q, (state == HI_ACC)};
            if (!op_rd_q) sram_wdata = (state == HI_ACC) ? wdata_q[15:8] : wdata_q[7:0];
        end
    end

    assign mem_resp  = (state == RESP);
    assign mem_rdata = rdata_q;

endmodule

// File: tb/tb_lc3b_mem_ctrl.sv
// Bench for lc3b_mem_ctrl: byte-wide SRAM model plus a word-level reference memory
// predicting per-cycle SRAM activity, response latency and read data.
module tb_lc3b_mem_ctrl;

    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_address;
    logic [15:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_byte_enable;
    logic [15:0] mem_rdata;
    logic        mem_resp;
    logic [15:0] sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata;
    logic        sram_ce;
    logic        sram_we;

    int checks = 0;
    int errors = 0;

    logic [7:0]  sram_mem [0:65535];
    logic [7:0]  ref_mem  [0:65535];
    logic [15:0] ref_rdata;

    lc3b_mem_ctrl #(.WAIT_STATES(W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .sram_addr       (sram_addr),
        .sram_wdata      (sram_wdata),
        .sram_rdata      (sram_rdata),
        .sram_ce         (sram_ce),
        .sram_we         (sram_we)
    );

    always #5 clk = ~clk;

    assign sram_rdata = sram_mem[sram_addr];

    always @(posedge clk) begin
        if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_wdata;
    end

    // One complete CPU transaction; expectations come from the byte-access schedule.
    task automatic do_txn(input logic rd, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wd, input logic [1:0] be,
                          input bit scramble, input int hold, input string tag);
        logic        sel [2];
        int          nacc;
        int          lat;
        int          j;
        logic        exp_ce;
        logic [15:0] exp_addr;
        logic [7:0]  exp_wd;
        logic [15:0] exp_rdata;
        logic [15:0] base;
        base = {addr[15:1], 1'b0};
        nacc = 0;
        if (rd) begin
            sel[0] = 1'b0; sel[1] = 1'b1; nacc = 2;
        end else begin
            if (be[0]) begin sel[nacc] = 1'b0; nacc++; end
            if (be[1]) begin sel[nacc] = 1'b1; nacc++; end
        end
        lat = nacc * W + 1;
        exp_rdata = rd ? {ref_mem[base | 16'h1], ref_mem[base]} : ref_rdata;

        mem_address = addr; mem_wdata = wd; mem_byte_enable = be;
        mem_read = rd; mem_write = wr;
        for (int k = 0; k <= lat; k++) begin
            if (k > 0) begin
                @(posedge clk); #1;
                if (scramble && k == 1) begin
                    mem_address = 16'($urandom); mem_wdata = 16'($urandom);
                    mem_byte_enable = 2'($urandom); mem_read = 1'($urandom);
                    mem_write = 1'($urandom);
                end
            end
            exp_ce = (k >= 1 && k < lat);
            checks++;
            if (mem_resp !== (k == lat)) begin
                errors++;
                $display("FAIL %s resp cycle %0d: got %b want %b", tag, k, mem_resp, (k == lat));
            end
            checks++;
            if (sram_ce !== exp_ce || sram_we !== (exp_ce && !rd)) begin
                errors++;
                $display("FAIL %s ce/we cycle %0d: got %b/%b want %b/%b", tag, k, sram_ce, sram_we,
                         exp_ce, (exp_ce && !rd));
            end
            if (exp_ce) begin
                j = (k - 1) / W;
                exp_addr = base | {15'd0, sel[j]};
                exp_wd = sel[j] ? wd[15:8] : wd[7:0];
                checks++;
                if (sram_addr !== exp_addr) begin
                    errors++;
                    $display("FAIL %s addr cycle %0d: got %h want %h", tag, k, sram_addr, exp_addr);
                end
                if (!rd) begin
                    checks++;
                    if (sram_wdata !== exp_wd) begin
                        errors++;
                        $display("FAIL %s wdata cycle %0d: got %h want %h", tag, k, sram_wdata, exp_wd);
                    end
                end
            end
            if (k == lat) begin
                checks++;
                if (mem_rdata !== exp_rdata) begin
                    errors++;
                    $display("FAIL %s rdata: got %h want %h", tag, mem_rdata, exp_rdata);
                end
            end
        end

        mem_read = rd; mem_write = wr;
        if (hold == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            checks++;
            if (sram_ce !== 1'b0 || mem_resp !== 1'b0) begin
                errors++;
                $display("FAIL %s held cycle %0d: ce %b resp %b want 0 0", tag, h, sram_ce, mem_resp);
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sram_ce !== 1'b0 || mem_resp !== 1'b0) begin
            errors++;
            $display("FAIL %s release: ce %b resp %b want 0 0", tag, sram_ce, mem_resp);
        end
        @(posedge clk); #1;

        if (rd) begin
            ref_rdata = exp_rdata;
        end else begin
            if (be[0]) ref_mem[base] = wd[7:0];
            if (be[1]) ref_mem[base | 16'h1] = wd[15:8];
        end
        checks++;
        if (sram_mem[base] !== ref_mem[base] || sram_mem[base | 16'h1] !== ref_mem[base | 16'h1]) begin
            errors++;
            $display("FAIL %s memory @%h: got %h%h want %h%h", tag, base, sram_mem[base | 16'h1],
                     sram_mem[base], ref_mem[base | 16'h1], ref_mem[base]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_address = 16'h0; mem_wdata = 16'h0; mem_read = 1'b0; mem_write = 1'b0;
        mem_byte_enable = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (sram_ce !== 1'b0 || sram_we !== 1'b0 || mem_resp !== 1'b0 || mem_rdata !== 16'h0000
            || sram_addr !== 16'h0000 || sram_wdata !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: ce %b we %b resp %b rdata %h addr %h wd %h want all zero",
                     sram_ce, sram_we, mem_resp, mem_rdata, sram_addr, sram_wdata);
        end
        rst_n = 1'b1;
        ref_rdata = 16'h0000;
        @(posedge clk); #1;
    endtask

    task automatic test_read();
        sram_mem[16'h1234] = 8'h34; ref_mem[16'h1234] = 8'h34;
        sram_mem[16'h1235] = 8'h12; ref_mem[16'h1235] = 8'h12;
        do_txn(1'b1, 1'b0, 16'h1235, 16'h0, 2'b00, 1'b0, 0, "read_1235");
        checks++;
        if (ref_rdata !== 16'h1234 || mem_rdata !== 16'h1234) begin
            errors++;
            $display("FAIL read_value: got %h want 1234", mem_rdata);
        end
    endtask

    // Reset lands in the first HI_ACC cycle of a full write with the request dropped.
    task automatic test_reset_abort();
        mem_address = 16'hF000; mem_wdata = 16'h1357; mem_byte_enable = 2'b11;
        mem_write = 1'b1; mem_read = 1'b0;
        repeat (W + 1) @(posedge clk);
        #1;
        checks++;
        if (sram_ce !== 1'b1 || sram_addr !== 16'hF001) begin
            errors++;
            $display("FAIL abort_in_hi: ce %b addr %h want 1 f001", sram_ce, sram_addr);
        end
        rst_n = 1'b0; mem_write = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (sram_ce !== 1'b0 || sram_we !== 1'b0 || mem_resp !== 1'b0 || mem_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL abort_reset: ce %b we %b resp %b rdata %h want 0 0 0 0000",
                     sram_ce, sram_we, mem_resp, mem_rdata);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        ref_rdata = 16'h0000;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(posedge clk); #1;
            checks++;
            if (mem_resp !== 1'b0 || sram_ce !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet cycle %0d: resp %b ce %b want 0 0", i, mem_resp, sram_ce);
            end
        end
    endtask

    task automatic test_masked_write();
        do_txn(1'b0, 1'b1, 16'h0040, 16'hBEEF, 2'b10, 1'b0, 0, "write_be10");
        checks++;
        if (sram_mem[16'h0041] !== 8'hBE) begin
            errors++;
            $display("FAIL masked_hi_byte: got %h want be", sram_mem[16'h0041]);
        end
    endtask

    task automatic test_empty_write();
        do_txn(1'b0, 1'b1, 16'h0300, 16'hFFFF, 2'b00, 1'b0, 0, "write_be00");
    endtask

    task automatic test_held_request();
        do_txn(1'b1, 1'b0, 16'h0500, 16'h0, 2'b00, 1'b0, 4, "held_first");
        do_txn(1'b1, 1'b0, 16'h0502, 16'h0, 2'b00, 1'b0, 0, "held_second");
    endtask

    task automatic test_full_write();
        do_txn(1'b0, 1'b1, 16'h2000, 16'hA55A, 2'b11, 1'b0, 0, "write_be11");
        checks++;
        if (sram_mem[16'h2000] !== 8'h5A || sram_mem[16'h2001] !== 8'hA5) begin
            errors++;
            $display("FAIL full_write_bytes: got %h%h want a55a", sram_mem[16'h2001], sram_mem[16'h2000]);
        end
    endtask

    task automatic test_read_wins();
        do_txn(1'b1, 1'b1, 16'h0700, 16'h9999, 2'b11, 1'b0, 0, "read_and_write");
        do_txn(1'b1, 1'b0, 16'h2001, 16'h0, 2'b01, 1'b0, 0, "readback_2000");
    endtask

    task automatic test_random();
        logic rd, wr;
        for (int n = 0; n < 40; n++) begin
            rd = 1'($urandom);
            wr = rd ? 1'($urandom) : 1'b1;
            do_txn(rd, wr, 16'($urandom_range(0, 16'hEFFF)), 16'($urandom), 2'($urandom),
                   1'($urandom), int'($urandom_range(0, 2)), "random");
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) begin
            sram_mem[a] = 8'($urandom);
            ref_mem[a]  = sram_mem[a];
        end
        test_reset();
        test_read();
        test_reset_abort();
        test_masked_write();
        test_empty_write();
        test_held_request();
        test_full_write();
        test_read_wins();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule
